// File: rtl/sc_obstacle_pkg.sv
// Shared encodings and field positions for the obstacle spawner slice.
// The random byte carries a gap field in its top bits and a lane field in its bottom bits.
package sc_obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GAP  = 2'b01,
    CAR  = 2'b10
  } sc_state_e;

  localparam int GAP_FIELD_MSB  = 7;
  localparam int GAP_FIELD_LSB  = 5;
  localparam int LANE_FIELD_MSB = 2;
  localparam int LANE_FIELD_LSB = 0;
  localparam int FIELD_W        = 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sc_lane_decoder.sv
// Clamps a 3-bit random lane field into the drivable road and expands it
// into a two-column car pattern.
module sc_lane_decoder
  import sc_obstacle_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int ROAD_LEFT  = 1,
  parameter int ROAD_RIGHT = 6,
  parameter int LANE_W     = $clog2(DATAWIDTH)
) (
  input  logic [FIELD_W-1:0]   field_i,
  output logic [LANE_W-1:0]    lane_o,
  output logic [DATAWIDTH-1:0] pattern_o
);

  localparam logic [LANE_W-1:0]    LANE_MIN = LANE_W'(ROAD_LEFT);
  localparam logic [LANE_W-1:0]    LANE_MAX = LANE_W'(ROAD_RIGHT - 1);
  localparam logic [DATAWIDTH-1:0] CAR_BASE = DATAWIDTH'(2'b11);

  logic [LANE_W-1:0] raw_s;

  assign raw_s = LANE_W'(field_i);

  // Lane clamp: the car is two columns wide, so its left column stops one short of ROAD_RIGHT.
  always_comb begin
    lane_o = LANE_MIN;
    if (raw_s < LANE_MIN) begin
      lane_o = LANE_MIN;
    end else if (raw_s > LANE_MAX) begin
      lane_o = LANE_MAX;
    end else begin
      lane_o = raw_s;
    end
  end

  assign pattern_o = CAR_BASE << lane_o;

endmodule

// File: rtl/sc_obstacle_spawner.sv
// Turns the LFSR byte into enemy-car rows (gap rows, then CAR_ROWS rows of a
// two-wide car) and emits one registered row per playfield shift tick.
module sc_obstacle_spawner
  import sc_obstacle_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int MIN_GAP    = 2,
  parameter int CAR_ROWS   = 2,
  parameter int ROAD_LEFT  = 1,
  parameter int ROAD_RIGHT = 6
) (
  input  logic                 SC_RegRANDOM_CLOCK_50,
  input  logic                 SC_RegRANDOM_RESET_InHigh,
  input  logic [DATAWIDTH-1:0] SC_ObstacleSpawner_random_InBUS,
  input  logic                 SC_ObstacleSpawner_tick_InHigh,
  input  logic                 SC_ObstacleSpawner_enable_InHigh,
  input  logic                 SC_ObstacleSpawner_clear_InHigh,
  output logic [DATAWIDTH-1:0] SC_ObstacleSpawner_row_OutBUS,
  output logic                 SC_ObstacleSpawner_rowValid_OutHigh,
  output logic [7:0]           SC_ObstacleSpawner_spawnCount_OutBUS
);

  localparam int                   LANE_W    = $clog2(DATAWIDTH);
  localparam int                   GAP_W     = 8;
  localparam logic [LANE_W-1:0]    LANE_INIT = LANE_W'(ROAD_LEFT);
  localparam logic [3:0]           CAR_LAST  = 4'(CAR_ROWS - 1);
  localparam logic [GAP_W-1:0]     GAP_BASE  = GAP_W'(MIN_GAP);
  localparam logic [DATAWIDTH-1:0] CAR_BASE  = DATAWIDTH'(2'b11);

  sc_state_e            state_q;
  logic [DATAWIDTH-1:0] row_q;
  logic                 row_valid_q;
  logic [7:0]           spawn_cnt_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [3:0]           car_cnt_q;
  logic [LANE_W-1:0]    lane_q;

  logic [GAP_W-1:0]     gap_load_s;
  logic [LANE_W-1:0]    lane_s;
  logic [DATAWIDTH-1:0] pattern_s;
  logic                 unused_random_s;

  assign gap_load_s = GAP_BASE
                    + GAP_W'(SC_ObstacleSpawner_random_InBUS[GAP_FIELD_MSB:GAP_FIELD_LSB]);

  // Bits between the lane and gap fields carry no meaning for this block.
  assign unused_random_s = ^SC_ObstacleSpawner_random_InBUS[GAP_FIELD_LSB-1:LANE_FIELD_MSB+1];

  sc_lane_decoder #(
    .DATAWIDTH (DATAWIDTH),
    .ROAD_LEFT (ROAD_LEFT),
    .ROAD_RIGHT(ROAD_RIGHT),
    .LANE_W    (LANE_W)
  ) u_lane_decoder (
    .field_i  (SC_ObstacleSpawner_random_InBUS[LANE_FIELD_MSB:LANE_FIELD_LSB]),
    .lane_o   (lane_s),
    .pattern_o(pattern_s)
  );

  // Spawner FSM with its counters and registered row outputs.
  always_ff @(posedge SC_RegRANDOM_CLOCK_50 or posedge SC_RegRANDOM_RESET_InHigh) begin
    if (SC_RegRANDOM_RESET_InHigh) begin
      state_q     <= IDLE;
      row_q       <= '0;
      row_valid_q <= 1'b0;
      spawn_cnt_q <= 8'd0;
      gap_cnt_q   <= '0;
      car_cnt_q   <= 4'd0;
      lane_q      <= LANE_INIT;
    end else if (SC_ObstacleSpawner_clear_InHigh) begin
      state_q     <= IDLE;
      row_q       <= '0;
      row_valid_q <= 1'b0;
      spawn_cnt_q <= 8'd0;
      gap_cnt_q   <= '0;
      car_cnt_q   <= 4'd0;
      lane_q      <= LANE_INIT;
    end else if (!SC_ObstacleSpawner_enable_InHigh) begin
      // Pausing keeps the spawn tally; only clear or reset zeroes it.
      state_q     <= IDLE;
      row_q       <= '0;
      row_valid_q <= 1'b0;
    end else begin
      row_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          row_q     <= '0;
          gap_cnt_q <= gap_load_s;
          state_q   <= GAP;
        end
        GAP: begin
          if (SC_ObstacleSpawner_tick_InHigh) begin
            row_valid_q <= 1'b1;
            if (gap_cnt_q != '0) begin
              gap_cnt_q <= gap_cnt_q - 8'd1;
              row_q     <= '0;
            end else begin
              lane_q      <= lane_s;
              row_q       <= pattern_s;
              car_cnt_q   <= CAR_LAST;
              spawn_cnt_q <= sat_inc8(spawn_cnt_q);
              state_q     <= CAR;
            end
          end
        end
        CAR: begin
          if (SC_ObstacleSpawner_tick_InHigh) begin
            row_valid_q <= 1'b1;
            row_q       <= CAR_BASE << lane_q;
            car_cnt_q   <= car_cnt_q - 4'd1;
            if (car_cnt_q == 4'd1) begin
              gap_cnt_q <= gap_load_s;
              state_q   <= GAP;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          row_q   <= '0;
        end
      endcase
    end
  end

  assign SC_ObstacleSpawner_row_OutBUS        = row_q;
  assign SC_ObstacleSpawner_rowValid_OutHigh  = row_valid_q;
  assign SC_ObstacleSpawner_spawnCount_OutBUS = spawn_cnt_q;

endmodule

// File: tb/tb_sc_obstacle_spawner.sv
// Directed scoreboard bench for sc_obstacle_spawner; a second instance with
// MIN_GAP = 0 exercises spawn-count saturation.
module tb_sc_obstacle_spawner;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       tick;
  logic       en;
  logic       en0;
  logic [7:0] rnd;

  logic [7:0] row;
  logic       valid;
  logic [7:0] cnt;
  logic [7:0] row0;
  logic       valid0;
  logic [7:0] cnt0;

  logic [7:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  sc_obstacle_spawner u_dut (
    .SC_RegRANDOM_CLOCK_50               (clk),
    .SC_RegRANDOM_RESET_InHigh           (rst),
    .SC_ObstacleSpawner_random_InBUS     (rnd),
    .SC_ObstacleSpawner_tick_InHigh      (tick),
    .SC_ObstacleSpawner_enable_InHigh    (en),
    .SC_ObstacleSpawner_clear_InHigh     (clear),
    .SC_ObstacleSpawner_row_OutBUS       (row),
    .SC_ObstacleSpawner_rowValid_OutHigh (valid),
    .SC_ObstacleSpawner_spawnCount_OutBUS(cnt)
  );

  sc_obstacle_spawner #(.MIN_GAP(0)) u_dut0 (
    .SC_RegRANDOM_CLOCK_50               (clk),
    .SC_RegRANDOM_RESET_InHigh           (rst),
    .SC_ObstacleSpawner_random_InBUS     (rnd),
    .SC_ObstacleSpawner_tick_InHigh      (tick),
    .SC_ObstacleSpawner_enable_InHigh    (en0),
    .SC_ObstacleSpawner_clear_InHigh     (clear),
    .SC_ObstacleSpawner_row_OutBUS       (row0),
    .SC_ObstacleSpawner_rowValid_OutHigh (valid0),
    .SC_ObstacleSpawner_spawnCount_OutBUS(cnt0)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one tick, queue the expected row, then compare once the DUT responds.
  task automatic tick_expect(input logic [7:0] r, input logic [7:0] exp_row, input string tag);
    logic [7:0] e;
    rnd  = r;
    tick = 1'b1;
    exp_q.push_back(exp_row);
    @(negedge clk);
    tick = 1'b0;
    check({tag, "_valid"}, {7'd0, valid}, 8'h01);
    e = exp_q.pop_front();
    check(tag, row, e);
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    tick  = 1'b1;
    en    = 1'b0;
    en0   = 1'b0;
    rnd   = 8'h99;

    // Reset with ticks applied, then ticks while disabled.
    @(negedge clk);
    @(negedge clk);
    check("rst_row", row, 8'h00);
    check("rst_valid", {7'd0, valid}, 8'h00);
    check("rst_cnt", cnt, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dis_valid", {7'd0, valid}, 8'h00);
    end
    check("dis_row", row, 8'h00);
    tick = 1'b0;

    // Enable: gap = 2 + 5 = 7 rows, then lane 3 car.
    rnd = 8'hA3;
    en  = 1'b1;
    @(negedge clk);
    check("en_valid", {7'd0, valid}, 8'h00);
    for (int i = 0; i < 7; i++) tick_expect(8'hA3, 8'h00, "gap_row");
    tick_expect(8'hA3, 8'h18, "car_row1");
    check("cnt_1", cnt, 8'h01);
    @(negedge clk);
    check("hold_valid", {7'd0, valid}, 8'h00);
    check("hold_row", row, 8'h18);
    tick_expect(8'hA3, 8'h18, "car_row2");
    tick_expect(8'hA3, 8'h00, "post_gap");

    // Lane clamps; gap reloads are 2 + 0.
    for (int i = 0; i < 6; i++) tick_expect(8'h00, 8'h00, "gap_a");
    tick_expect(8'h00, 8'h06, "clamp0");
    tick_expect(8'h00, 8'h06, "clamp0_b");
    for (int i = 0; i < 2; i++) tick_expect(8'h00, 8'h00, "gap_b");
    tick_expect(8'h07, 8'h60, "clamp7");
    tick_expect(8'h07, 8'h60, "clamp7_b");
    for (int i = 0; i < 2; i++) tick_expect(8'h00, 8'h00, "gap_c");
    tick_expect(8'h05, 8'h60, "clamp5");
    tick_expect(8'h05, 8'h60, "clamp5_b");
    check("cnt_4", cnt, 8'h04);

    // Enable dropped after the first car row.
    for (int i = 0; i < 2; i++) tick_expect(8'h00, 8'h00, "gap_d");
    tick_expect(8'h04, 8'h30, "lane4");
    check("cnt_5", cnt, 8'h05);
    en = 1'b0;
    @(negedge clk);
    check("drop_row", row, 8'h00);
    check("drop_valid", {7'd0, valid}, 8'h00);
    check("drop_cnt", cnt, 8'h05);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("drop_tick_valid", {7'd0, valid}, 8'h00);

    // Re-enable: fresh gap 2 + 1 = 3 from the enable cycle only.
    rnd = 8'h20;
    en  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick_expect(8'hFF, 8'h00, "regap");
    tick_expect(8'h02, 8'h0C, "lane2");
    check("cnt_6", cnt, 8'h06);
    tick_expect(8'h00, 8'h0C, "lane2_b");

    // Clear together with a tick in GAP.
    rnd   = 8'h00;
    clear = 1'b1;
    tick  = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tick  = 1'b0;
    check("clr_valid", {7'd0, valid}, 8'h00);
    check("clr_row", row, 8'h00);
    check("clr_cnt", cnt, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 2; i++) tick_expect(8'h00, 8'h00, "gap_e");
    tick_expect(8'h03, 8'h18, "post_clear");
    check("cnt_after_clr", cnt, 8'h01);

    // Asynchronous reset between clock edges.
    #3 rst = 1'b1;
    #1;
    check("async_row", row, 8'h00);
    check("async_cnt", cnt, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    // Saturation on the MIN_GAP = 0 instance with back-to-back ticks.
    rnd = 8'h00;
    en0 = 1'b1;
    @(negedge clk);
    tick = 1'b1;
    repeat (508) @(negedge clk);
    check("sat_254", cnt0, 8'hFE);
    repeat (2) @(negedge clk);
    check("sat_255", cnt0, 8'hFF);
    repeat (20) @(negedge clk);
    check("sat_hold", cnt0, 8'hFF);
    check("sat_row", row0, 8'h06);
    check("sat_valid", {7'd0, valid0}, 8'h01);
    check("main_idle_cnt", cnt, 8'h00);
    tick = 1'b0;
    en0  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sc_obstacle_spawner.md
Name: sc_obstacle_spawner

Overview:
- Sits directly downstream of the 8-bit LFSR random register and consumes its output byte.
- Turns the random value into enemy-car rows for the top row of the road matrix: a lane choice, a car pattern two columns wide and CAR_ROWS rows tall, and a random gap between cars.
- Emits one row pattern per row-shift tick to the playfield shift register.

Parameters:
- DATAWIDTH, 8, width of the random input and of the row output.
- MIN_GAP, 2, minimum number of empty rows between cars.
- CAR_ROWS, 2, rows per car; legal range 2..15.
- ROAD_LEFT, 1, leftmost column a car may occupy.
- ROAD_RIGHT, 6, rightmost column a car may occupy; requires ROAD_RIGHT > ROAD_LEFT.

Ports:
- SC_RegRANDOM_CLOCK_50, in, 1, system clock, 50 MHz, rising edge.
- SC_RegRANDOM_RESET_InHigh, in, 1, reset, asynchronous, active-high.
- SC_ObstacleSpawner_random_InBUS, in, DATAWIDTH, current LFSR value.
- SC_ObstacleSpawner_tick_InHigh, in, 1, one-cycle pulse per playfield row shift.
- SC_ObstacleSpawner_enable_InHigh, in, 1, level; high while the game is running.
- SC_ObstacleSpawner_clear_InHigh, in, 1, synchronous clear (game over / restart).
- SC_ObstacleSpawner_row_OutBUS, out, DATAWIDTH, registered new top-row pattern.
- SC_ObstacleSpawner_rowValid_OutHigh, out, 1, one-cycle pulse when the row output is updated.
- SC_ObstacleSpawner_spawnCount_OutBUS, out, 8, number of cars spawned; saturates at 255.

Behaviour:
- Reset (async) and clear (sync) have identical effect:
  - state = IDLE, row = 0, rowValid = 0, spawnCount = 0, gap_cnt = 0, car_cnt = 0, lane = ROAD_LEFT.
- Priority: reset > clear > enable low > tick.
- FSM states: IDLE, GAP, CAR.
- IDLE:
  - Row held at 0; ticks are ignored and rowValid stays 0.
  - When enable = 1: gap_cnt <= MIN_GAP + random[7:5], next state GAP.
- GAP, on tick:
  - If gap_cnt != 0: gap_cnt decrements, row <= 0, rowValid pulses.
  - If gap_cnt == 0: lane <= clamp(random[2:0]), row <= car pattern, car_cnt <= CAR_ROWS-1, spawnCount increments (saturating), next state CAR.
- CAR, on tick:
  - row <= the same car pattern, rowValid pulses, car_cnt decrements.
  - When car_cnt == 1 before the decrement, this is the last car row: gap_cnt <= MIN_GAP + random[7:5], next state GAP.
- Lane clamp:
  - If r < ROAD_LEFT, lane = ROAD_LEFT.
  - If r > ROAD_RIGHT-1, lane = ROAD_RIGHT-1.
  - Otherwise lane = r.
- Car pattern: bits lane and lane+1 set, all other bits 0.
- Random sampling: the random input is sampled only on the tick cycle that makes the decision (gap load or lane latch). No other bits are used.
- Gap is MIN_GAP..MIN_GAP+7 empty rows.
- Latency: row and rowValid update on the clock edge after the tick cycle (1 cycle). With no tick, row holds its value and rowValid = 0.
- Enable falling in any state:
  - Next edge: state = IDLE, row = 0, no rowValid pulse.
  - spawnCount is preserved; only clear or reset zeroes it.
- Back-to-back ticks on consecutive cycles are each processed; there is no minimum tick spacing.
- A tick coincident with clear or enable low is discarded.

Decomposition:
- Package sc_obstacle_pkg holds:
  - state encoding constants IDLE = 2'b00, GAP = 2'b01, CAR = 2'b10;
  - the gap-field and lane-field bit positions.
- Sub-module sc_lane_decoder (combinational):
  - Inputs: 3-bit random field.
  - Output: clamped, two-hot DATAWIDTH-bit car pattern.
  - ROAD_LEFT and ROAD_RIGHT are passed through.
- FSM, counters and output registers live in the top module.

Test Plan:
- Reset with random = 8'h99, enable = 0, ticks applied -> row = 8'h00, rowValid never asserts, spawnCount = 0.
- Enable with random = 8'b101_00_011, then 10 ticks -> first 7 ticks give row 8'h00, 8th and 9th give 8'h18, spawnCount = 1, 10th gives 8'h00.
- Lane clamp: lane field 0 -> car row 8'h06; lane field 7 -> 8'h60; lane field 5 -> 8'h60.
- Enable dropped mid-CAR (after the first car row) -> next cycle row = 8'h00, state IDLE, spawnCount unchanged. Re-enable -> fresh gap is loaded from random[7:5].
- Clear asserted together with a tick in GAP -> no rowValid pulse, all outputs 0. Async reset mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
- Force spawnCount to 255 with MIN_GAP = 0 and a long run -> count holds at 8'hFF after further spawns.
